port_hold_arbiter: RTL and testbench
====================================

PORT_HOLD_ARBITER -- requirements
Module: port_hold_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: c_clk and reset.
REQ-002 SHALL have ports:
  c_clk  in  1  clock, rising edge
  reset  in  1  async active-high reset
  reqN_cmd_in (N=1..4)  in  4  port command; 0 = no-op
  reqN_data_in (N=1..4)  in  32  operand 1 in cmd cycle, operand 2 in the next cycle
  reqN_busy (N=1..4)  out  1  port slot occupied
  holdN_data1, holdN_data2 (N=1..4)  out  32  captured operands, direct from slot registers
  prio_alu_in_cmd  out  4  issued command
  prio_alu_in_req_id  out  2  issued port, 0..3 = ports 1..4
  prio_alu_in_valid  out  1  issue register holds a command
  alu_ready  in  1  ALU accepts the issued command this cycle
REQ-003 SHALL drive every output from a register; no combinational input-to-output path.

Function
REQ-004 Each port SHALL have its own slot FSM with states IDLE, WAIT_D2, PENDING and ISSUED.
REQ-005 IDLE: nonzero reqN_cmd_in -> capture cmd and reqN_data_in into holdN_data1; go to WAIT_D2.
REQ-006 WAIT_D2: capture reqN_data_in into holdN_data2 unconditionally; go to PENDING.
REQ-007 PENDING: go to ISSUED on the edge the arbiter loads this port into the issue register.
REQ-008 ISSUED: go to IDLE on the edge where prio_alu_in_valid && alu_ready.
REQ-009 reqN_busy SHALL be 1 in every state except IDLE.
REQ-010 A nonzero command arriving outside IDLE SHALL be ignored, with no change to slot data or state.
REQ-011 holdN_data1 and holdN_data2 SHALL change only on a capture; they stay stable through PENDING, ISSUED and after the return to IDLE.
REQ-012 Issue register load condition: (!prio_alu_in_valid || alu_ready) and at least one slot PENDING.
  - On load: cmd, req_id and valid=1 from the selected port.
REQ-013 The issue register SHALL clear valid when alu_ready=1 and no slot is PENDING.
REQ-014 Otherwise the issue register SHALL hold cmd, req_id and valid unchanged (backpressure).
REQ-015 Back-to-back issue: a new load SHALL happen in the same edge as the previous accept, giving 1 issue per cycle.
REQ-016 Minimum latency: cmd at cycle T -> prio_alu_in_valid=1 in cycle T+3.
REQ-017 A slot freed at edge E SHALL accept a new command sampled at that same edge E+1 onward; reqN_busy=0 in the cycle after E.
REQ-018 Port selection SHALL follow REQ-024/REQ-025.

Reset
REQ-019 When reset=1, all slots SHALL go to IDLE immediately, independent of c_clk.
REQ-020 When reset=1, all hold, cmd and req_id registers SHALL clear to 0, and prio_alu_in_valid and reqN_busy to 0.
REQ-021 When reset=1, the round-robin pointer SHALL load 3, so port 1 is checked first.
REQ-022 Reset mid-operation SHALL discard every in-flight command with no issue.
REQ-023 The first command SHALL be sampled on the first rising edge after reset deasserts.

Configuration
REQ-024 With ROUND_ROBIN_EN defined, the search SHALL start at pointer+1 modulo 4 and pick the first PENDING port.
  - The pointer updates to the granted req_id on each load.
REQ-025 Without ROUND_ROBIN_EN, fixed priority SHALL apply: port 1 > 2 > 3 > 4, and the pointer logic is absent.

Verification
REQ-026 Single op: port1 cmd=1, data 0x00000005 then 0x00000003, alu_ready=1.
  -> hold1_data1=5, hold1_data2=3; valid=1, cmd=1, req_id=0 at T+3; busy1=0 at T+5.
REQ-027 Ignored command: port2 cmd=2, data 0xA/0xB, then cmd=1 with data 0xFFFFFFFF while busy2=1.
  -> hold2_data1 stays 0xA, hold2_data2 stays 0xB; only cmd 2 issues.
REQ-028 All four ports load together, alu_ready=1.
  -> ROUND_ROBIN_EN: req_id 0,1,2,3 on consecutive cycles.
  -> Then reload all ports after port3 last granted: next order 3,0,1,2.
  -> Without ROUND_ROBIN_EN: reload order is 0,1,2,3.
REQ-029 Backpressure: alu_ready=0 for 5 cycles with port4 issued.
  -> valid, cmd and req_id=3 stable for all 5 cycles, busy4=1.
  -> Single accept when alu_ready=1.
REQ-030 Reset asserted mid-operation, with port1 in WAIT_D2 and port2 ISSUED.
  -> All busy=0, valid=0, all hold registers=0 without a clock edge.
  -> No issue after release until a new command.

Source files
------------

// File: rtl/port_hold_arbiter.sv
// port_hold_arbiter: four command ports, each with a two-operand hold slot,
// feeding a single registered issue stage towards an ALU.
// Optional feature: define ROUND_ROBIN_EN for round-robin port selection;
// the default build uses fixed priority (port 1 highest).
// All outputs come straight from registers.

module port_hold_arbiter (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [31:0] req2_data_in,
  input  logic [31:0] req3_data_in,
  input  logic [31:0] req4_data_in,
  output logic        req1_busy,
  output logic        req2_busy,
  output logic        req3_busy,
  output logic        req4_busy,
  output logic [31:0] hold1_data1,
  output logic [31:0] hold1_data2,
  output logic [31:0] hold2_data1,
  output logic [31:0] hold2_data2,
  output logic [31:0] hold3_data1,
  output logic [31:0] hold3_data2,
  output logic [31:0] hold4_data1,
  output logic [31:0] hold4_data2,
  output logic [3:0]  prio_alu_in_cmd,
  output logic [1:0]  prio_alu_in_req_id,
  output logic        prio_alu_in_valid,
  input  logic        alu_ready
);

  localparam int unsigned NumPorts = 4;

  typedef enum logic [1:0] {StIdle, StWaitD2, StPending, StIssued} slot_state_e;

  logic [3:0]  cmd_in  [NumPorts];
  logic [31:0] data_in [NumPorts];

  slot_state_e state_q [NumPorts];
  slot_state_e state_d [NumPorts];
  logic [3:0]  cmd_q   [NumPorts];
  logic [31:0] data1_q [NumPorts];
  logic [31:0] data2_q [NumPorts];
  logic [NumPorts-1:0] busy_q;
  logic [NumPorts-1:0] capture1;
  logic [NumPorts-1:0] capture2;
  logic [NumPorts-1:0] pending;

  logic [3:0] issue_cmd_q, issue_cmd_d;
  logic [1:0] issue_id_q, issue_id_d;
  logic       issue_valid_q, issue_valid_d;
  logic [1:0] grant_id;
  logic       load;
  logic       accept;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign req1_busy   = busy_q[0];
  assign req2_busy   = busy_q[1];
  assign req3_busy   = busy_q[2];
  assign req4_busy   = busy_q[3];
  assign hold1_data1 = data1_q[0];
  assign hold1_data2 = data2_q[0];
  assign hold2_data1 = data1_q[1];
  assign hold2_data2 = data2_q[1];
  assign hold3_data1 = data1_q[2];
  assign hold3_data2 = data2_q[2];
  assign hold4_data1 = data1_q[3];
  assign hold4_data2 = data2_q[3];

  assign prio_alu_in_cmd    = issue_cmd_q;
  assign prio_alu_in_req_id = issue_id_q;
  assign prio_alu_in_valid  = issue_valid_q;

  // Slots waiting for the issue stage.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NumPorts; i++) begin
      pending[i] = (state_q[i] == StPending);
    end
  end

  // Accept retires the current issue; load refills the stage in the same edge.
  always_comb begin
    accept = issue_valid_q && alu_ready;
    load   = (!issue_valid_q || alu_ready) && (|pending);
  end

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    idx      = '0;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && pending[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  // Pointer follows the most recent grant.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = grant_id;
    end
  end

  // Pointer register; reset value 3 makes port 1 the first candidate.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest port number wins.
  always_comb begin
    grant_id = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (pending[k]) begin
        grant_id = 2'(k);
      end
    end
  end
`endif

  // Per-port slot FSM next state and capture strobes.
  always_comb begin
    capture1 = '0;
    capture2 = '0;
    for (int i = 0; i < NumPorts; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (cmd_in[i] != 4'd0) begin
            state_d[i]  = StWaitD2;
            capture1[i] = 1'b1;
          end
        end
        StWaitD2: begin
          state_d[i]  = StPending;
          capture2[i] = 1'b1;
        end
        StPending: begin
          if (load && (grant_id == 2'(i))) begin
            state_d[i] = StIssued;
          end
        end
        StIssued: begin
          // Only one slot can be issued at a time, so any accept retires it.
          if (accept) begin
            state_d[i] = StIdle;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Slot state, captured operands and registered busy flags.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < NumPorts; i++) begin
        state_q[i] <= StIdle;
        cmd_q[i]   <= '0;
        data1_q[i] <= '0;
        data2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        state_q[i] <= state_d[i];
        busy_q[i]  <= (state_d[i] != StIdle);
        if (capture1[i]) begin
          cmd_q[i]   <= cmd_in[i];
          data1_q[i] <= data_in[i];
        end
        if (capture2[i]) begin
          data2_q[i] <= data_in[i];
        end
      end
    end
  end

  // Issue stage next state: load, drain when idle, otherwise hold.
  always_comb begin
    issue_cmd_d   = issue_cmd_q;
    issue_id_d    = issue_id_q;
    issue_valid_d = issue_valid_q;
    if (load) begin
      issue_cmd_d   = cmd_q[grant_id];
      issue_id_d    = grant_id;
      issue_valid_d = 1'b1;
    end else if (alu_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  // Issue stage register.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      issue_cmd_q   <= '0;
      issue_id_q    <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      issue_cmd_q   <= issue_cmd_d;
      issue_id_q    <= issue_id_d;
      issue_valid_q <= issue_valid_d;
    end
  end

endmodule

// File: tb/tb_port_hold_arbiter.sv
// Self-checking bench for port_hold_arbiter: directed scenarios plus random
// traffic, every cycle compared against a behavioural model of the ports.
// Honours ROUND_ROBIN_EN the same way the design does.

module tb_port_hold_arbiter;

  logic        c_clk;
  logic        reset;
  logic [3:0]  req_cmd  [4];
  logic [31:0] req_data [4];
  logic        alu_ready;
  logic        req_busy [4];
  logic [31:0] hold_d1  [4];
  logic [31:0] hold_d2  [4];
  logic [3:0]  prio_alu_in_cmd;
  logic [1:0]  prio_alu_in_req_id;
  logic        prio_alu_in_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 free, 1 awaiting operand 2, 2 waiting for issue, 3 issued.
  int          m_phase [4];
  logic [3:0]  m_cmd   [4];
  logic [31:0] m_d1    [4];
  logic [31:0] m_d2    [4];
  logic        m_valid;
  logic [3:0]  m_icmd;
  int          m_id;
  int          m_ptr;
  int          id_q [$];

  port_hold_arbiter dut (
    .c_clk              (c_clk),
    .reset              (reset),
    .req1_cmd_in        (req_cmd[0]),
    .req2_cmd_in        (req_cmd[1]),
    .req3_cmd_in        (req_cmd[2]),
    .req4_cmd_in        (req_cmd[3]),
    .req1_data_in       (req_data[0]),
    .req2_data_in       (req_data[1]),
    .req3_data_in       (req_data[2]),
    .req4_data_in       (req_data[3]),
    .req1_busy          (req_busy[0]),
    .req2_busy          (req_busy[1]),
    .req3_busy          (req_busy[2]),
    .req4_busy          (req_busy[3]),
    .hold1_data1        (hold_d1[0]),
    .hold1_data2        (hold_d2[0]),
    .hold2_data1        (hold_d1[1]),
    .hold2_data2        (hold_d2[1]),
    .hold3_data1        (hold_d1[2]),
    .hold3_data2        (hold_d2[2]),
    .hold4_data1        (hold_d1[3]),
    .hold4_data2        (hold_d2[3]),
    .prio_alu_in_cmd    (prio_alu_in_cmd),
    .prio_alu_in_req_id (prio_alu_in_req_id),
    .prio_alu_in_valid  (prio_alu_in_valid),
    .alu_ready          (alu_ready)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 0;
      m_cmd[i]   = '0;
      m_d1[i]    = '0;
      m_d2[i]    = '0;
    end
    m_valid = 1'b0;
    m_icmd  = '0;
    m_id    = 0;
    m_ptr   = 3;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    int  sel;
    bit  acc;
    bit  ld;
    acc = m_valid && alu_ready;
    sel = -1;
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (m_ptr + k) % 4;
      if (sel < 0 && m_phase[p] == 2) sel = p;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (sel < 0 && m_phase[k] == 2) sel = k;
    end
`endif
    ld = (!m_valid || alu_ready) && (sel >= 0);
    for (int i = 0; i < 4; i++) begin
      case (m_phase[i])
        0: if (req_cmd[i] != 4'd0) begin
             m_phase[i] = 1;
             m_cmd[i]   = req_cmd[i];
             m_d1[i]    = req_data[i];
           end
        1: begin
             m_phase[i] = 2;
             m_d2[i]    = req_data[i];
           end
        2: if (ld && sel == i) m_phase[i] = 3;
        default: if (acc) m_phase[i] = 0;
      endcase
    end
    if (ld) begin
      m_icmd  = m_cmd[sel];
      m_id    = sel;
      m_valid = 1'b1;
      m_ptr   = sel;
    end else if (alu_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("busy%0d", i + 1), 32'(req_busy[i]), 32'(m_phase[i] != 0));
      check_eq($sformatf("hold%0d_data1", i + 1), hold_d1[i], m_d1[i]);
      check_eq($sformatf("hold%0d_data2", i + 1), hold_d2[i], m_d2[i]);
    end
    check_eq("valid", 32'(prio_alu_in_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("issue_cmd", 32'(prio_alu_in_cmd), 32'(m_icmd));
      check_eq("issue_req_id", 32'(prio_alu_in_req_id), 32'(m_id));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_busy%0d", tag, i + 1), 32'(req_busy[i]), 32'd0);
      check_eq($sformatf("%s_hold%0d_d1", tag, i + 1), hold_d1[i], 32'd0);
      check_eq($sformatf("%s_hold%0d_d2", tag, i + 1), hold_d2[i], 32'd0);
    end
    check_eq({tag, "_valid"}, 32'(prio_alu_in_valid), 32'd0);
    check_eq({tag, "_cmd"}, 32'(prio_alu_in_cmd), 32'd0);
    check_eq({tag, "_req_id"}, 32'(prio_alu_in_req_id), 32'd0);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_cmd[i]  = '0;
      req_data[i] = '0;
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge c_clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    clear_inputs();
    @(negedge c_clk);
    reset = 1'b0;
  endtask

  task automatic load_ports(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      req_cmd[i]  = mask[i] ? 4'(i + 1) : 4'd0;
      req_data[i] = $urandom;
    end
    step();
    for (int i = 0; i < 4; i++) begin
      req_cmd[i]  = '0;
      req_data[i] = $urandom;
    end
    step();
    clear_inputs();
  endtask

  task automatic collect_ids(input int n);
    id_q.delete();
    for (int c = 0; c < 20 && id_q.size() < n; c++) begin
      step();
      if (prio_alu_in_valid) id_q.push_back(int'(prio_alu_in_req_id));
    end
    while (id_q.size() < 4) id_q.push_back(-1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while ((req_busy[0] || req_busy[1] || req_busy[2] || req_busy[3] || prio_alu_in_valid)
           && c < 20) begin
      step();
      c++;
    end
    check_eq({tag, "_drain"}, 32'(c < 20), 32'd1);
  endtask

  task automatic check_order(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3);
    int exp_ids [4];
    exp_ids = '{e0, e1, e2, e3};
    for (int j = 0; j < n; j++) begin
      check_eq($sformatf("%s_%0d", tag, j), 32'(id_q[j]), 32'(exp_ids[j]));
    end
  endtask

  initial begin
    int issues;
    reset     = 1'b1;
    alu_ready = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge c_clk);
    reset = 1'b0;

    // Single operation on port 1.
    alu_ready   = 1'b1;
    req_cmd[0]  = 4'd1;
    req_data[0] = 32'h0000_0005;
    step();
    req_cmd[0]  = 4'd0;
    req_data[0] = 32'h0000_0003;
    step();
    req_data[0] = 32'h0;
    step();
    check_eq("single_valid_t3", 32'(prio_alu_in_valid), 32'd1);
    check_eq("single_cmd_t3", 32'(prio_alu_in_cmd), 32'd1);
    check_eq("single_id_t3", 32'(prio_alu_in_req_id), 32'd0);
    check_eq("single_hold1_d1", hold_d1[0], 32'h5);
    check_eq("single_hold1_d2", hold_d2[0], 32'h3);
    step();
    step();
    check_eq("single_busy1_t5", 32'(req_busy[0]), 32'd0);

    // Command to a busy port is ignored.
    alu_ready   = 1'b0;
    req_cmd[1]  = 4'd2;
    req_data[1] = 32'hA;
    step();
    req_cmd[1]  = 4'd0;
    req_data[1] = 32'hB;
    step();
    req_cmd[1]  = 4'd1;
    req_data[1] = 32'hFFFF_FFFF;
    step();
    step();
    check_eq("ign_hold2_d1", hold_d1[1], 32'hA);
    check_eq("ign_hold2_d2", hold_d2[1], 32'hB);
    check_eq("ign_cmd", 32'(prio_alu_in_cmd), 32'd2);
    check_eq("ign_busy2", 32'(req_busy[1]), 32'd1);
    clear_inputs();
    alu_ready = 1'b1;
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (prio_alu_in_valid) issues++;
    end
    check_eq("ign_extra_issues", 32'(issues), 32'd0);
    check_eq("ign_hold2_d1_after", hold_d1[1], 32'hA);

    // Backpressure with port 4 issued.
    alu_ready   = 1'b0;
    req_cmd[3]  = 4'd5;
    req_data[3] = 32'h1234_5678;
    step();
    req_cmd[3]  = 4'd0;
    req_data[3] = 32'h9ABC_DEF0;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("bp_valid_%0d", c), 32'(prio_alu_in_valid), 32'd1);
      check_eq($sformatf("bp_cmd_%0d", c), 32'(prio_alu_in_cmd), 32'd5);
      check_eq($sformatf("bp_id_%0d", c), 32'(prio_alu_in_req_id), 32'd3);
      check_eq($sformatf("bp_busy4_%0d", c), 32'(req_busy[3]), 32'd1);
      if (c < 4) step();
    end
    alu_ready = 1'b1;
    step();
    check_eq("bp_accept_valid", 32'(prio_alu_in_valid), 32'd0);
    check_eq("bp_accept_busy4", 32'(req_busy[3]), 32'd0);
    step();
    check_eq("bp_single_accept", 32'(prio_alu_in_valid), 32'd0);

    // Arbitration order, starting from a fresh pointer.
    do_reset("rst_order");
    alu_ready = 1'b1;
    load_ports(4'b1111);
    collect_ids(4);
    check_order("order_all", 4, 0, 1, 2, 3);
    wait_idle("order_all");
    load_ports(4'b0111);
    collect_ids(3);
    check_order("order_three", 3, 0, 1, 2, 0);
    wait_idle("order_three");
    load_ports(4'b1111);
    collect_ids(4);
`ifdef ROUND_ROBIN_EN
    check_order("order_reload", 4, 3, 0, 1, 2);
`else
    check_order("order_reload", 4, 0, 1, 2, 3);
`endif
    wait_idle("order_reload");

    // Reset with port 1 awaiting operand 2 and port 2 issued.
    alu_ready   = 1'b0;
    req_cmd[1]  = 4'd9;
    req_data[1] = 32'h1111;
    step();
    req_cmd[1]  = 4'd0;
    req_data[1] = 32'h2222;
    step();
    step();
    req_cmd[0]  = 4'd4;
    req_data[0] = 32'h3333;
    step();
    check_eq("midrst_busy1", 32'(req_busy[0]), 32'd1);
    check_eq("midrst_valid", 32'(prio_alu_in_valid), 32'd1);
    do_reset("midrst");
    alu_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq($sformatf("midrst_noissue_%0d", c), 32'(prio_alu_in_valid), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_cmd[i]  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        req_data[i] = $urandom;
      end
      alu_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
